// File: rtl/adc_sample_scheduler.sv
// Request-driven, fair, mux-aware frame sequencer for a shared serial ADC.
// Optional feature macro: ADC_SCHED_MUX_SKIP_EN (skip settle if mux unchanged).
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req[1:0]          level conversion requests (bit0 = twin A, bit1 = twin B)
//   ack[1:0]          one-cycle pulse when the requester's sample is delivered
//   smp_valid         one-cycle pulse, smp_data/smp_ch valid
//   smp_data          captured sample, MSB first
//   smp_ch            channel of the sample
//   busy              FSM not in IDLE
//   mux_sel           analog mux select (0 = A, 1 = B)
//   adc_cs_n, adc_sck ADC chip select / serial clock
//   adc_sdo           ADC serial data
module adc_sample_scheduler #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 16,
    parameter int LEAD      = 2,
    parameter int SETTLE    = 4,
    parameter int GAP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic [1:0]        ack,
    output logic              smp_valid,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_ch,
    output logic              busy,
    output logic              mux_sel,
    output logic              adc_cs_n,
    output logic              adc_sck,
    input  logic              adc_sdo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_FRAME,
        S_GAP
    } state_t;

    localparam int CW = $clog2(2*FRAME_LEN + SETTLE + GAP + 1);

    state_t            st, st_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              ch, ch_n;
    logic              last, last_n;
    logic [DATA_W-1:0] sr, sr_n;
    logic [1:0]        ack_n;
    logic              valid_n;
    logic [DATA_W-1:0] data_n;
    logic              sch_n;
    logic              busy_n;
    logic              mux_n;
    logic              cs_n_n;
    logic              sck_n;
    logic              g;

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        ch_n    = ch;
        last_n  = last;
        sr_n    = sr;
        ack_n   = 2'b00;
        valid_n = 1'b0;
        data_n  = smp_data;
        sch_n   = smp_ch;
        mux_n   = mux_sel;
        cs_n_n  = adc_cs_n;
        sck_n   = adc_sck;
        g       = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (|req) begin
                    // Both pending: alternate away from the last served twin.
                    g     = (req == 2'b11) ? ~last : req[1];
                    ch_n  = g;
                    mux_n = g;
                    cnt_n = '0;
`ifdef ADC_SCHED_MUX_SKIP_EN
                    st_n  = (g == mux_sel) ? S_FRAME : S_SETTLE;
`else
                    st_n  = S_SETTLE;
`endif
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(SETTLE-1)) begin
                    st_n  = S_FRAME;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_FRAME: begin
                if (cnt == '0) begin
                    // First frame cycle only lowers CS; SCK starts low.
                    cs_n_n = 1'b0;
                    cnt_n  = cnt + 1'b1;
                end else if (cnt == CW'(2*FRAME_LEN)) begin
                    cs_n_n  = 1'b1;
                    sck_n   = 1'b0;
                    data_n  = sr;
                    sch_n   = ch;
                    valid_n = 1'b1;
                    ack_n   = ch ? 2'b10 : 2'b01;
                    last_n  = ch;
                    st_n    = S_GAP;
                    cnt_n   = '0;
                end else begin
                    sck_n = ~adc_sck;
                    // Odd counts drive SCK high; count 2k+1 is edge k.
                    if (!adc_sck &&
                        cnt >= CW'(2*LEAD+1) &&
                        cnt <= CW'(2*(LEAD+DATA_W)-1))
                        sr_n = {sr[DATA_W-2:0], adc_sdo};
                    cnt_n = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == CW'(GAP-1)) begin
                    st_n  = S_IDLE;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
        busy_n = (st_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            cnt       <= '0;
            ch        <= 1'b0;
            last      <= 1'b1;
            sr        <= '0;
            ack       <= 2'b00;
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_ch    <= 1'b0;
            busy      <= 1'b0;
            mux_sel   <= 1'b0;
            adc_cs_n  <= 1'b1;
            adc_sck   <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            ch        <= ch_n;
            last      <= last_n;
            sr        <= sr_n;
            ack       <= ack_n;
            smp_valid <= valid_n;
            smp_data  <= data_n;
            smp_ch    <= sch_n;
            busy      <= busy_n;
            mux_sel   <= mux_n;
            adc_cs_n  <= cs_n_n;
            adc_sck   <= sck_n;
        end
    end

endmodule
